// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined multiplier among NREQ requesters.
// A {valid, id} tag rides alongside the multiplier pipeline so each product returns to its owner.
module mult_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 18,
  parameter int unsigned LAT  = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic [2*W-1:0]      mul_p,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_data,
  output logic                busy,
  output logic [15:0]         issue_cnt
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] sel;
  logic [W-1:0]   grant_a;
  logic [W-1:0]   grant_b;
  logic           xfer;
  int unsigned    idx;

  // Stage 0 is loaded on issue; stage LAT lines up with mul_p.
  logic [LAT:0]   tag_vld;
  logic [IDW-1:0] tag_id [LAT+1];

  // Search ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    grant_a   = '0;
    grant_b   = '0;
    xfer      = 1'b0;
    idx       = 0;
    sel       = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        sel = IDW'(idx);
        if (!xfer && req_valid[sel]) begin
          xfer           = 1'b1;
          req_ready[sel] = 1'b1;
          grant_id       = sel;
          grant_a        = req_a[sel*W +: W];
          grant_b        = req_b[sel*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_cnt <= '0;
      tag_vld   <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tag_id[k] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      tag_vld[0] <= xfer;
      if (xfer) begin
        tag_id[0] <= grant_id;
        mul_a     <= grant_a;
        mul_b     <= grant_b;
        ptr       <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        issue_cnt <= issue_cnt + 16'd1;
      end
      // The multiplier cannot stall, so the tag shift never stalls either.
      for (int unsigned k = 1; k <= LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
      rsp_valid <= tag_vld[LAT];
      if (tag_vld[LAT]) begin
        rsp_id   <= tag_id[LAT];
        rsp_data <= mul_p;
      end
    end
  end

  assign busy = |tag_vld;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural fixed-latency multiplier model.
module tb_mult_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 18;
  localparam int unsigned LAT  = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [W-1:0]        mul_a;
  logic [W-1:0]        mul_b;
  logic [2*W-1:0]      mul_p;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_data;
  logic                busy;
  logic [15:0]         issue_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cycnum   = 0;
  int rsp_cnt  = 0;
  int rq_id [$];
  longint rq_data [$];
  int rq_cyc [$];

  mult_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier: samples mul_a/mul_b one edge after issue, product held after issue edge + LAT.
  logic [2*W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[LAT-1];

  always @(posedge clk) cycnum <= cycnum + 1;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rq_id.push_back(int'(rsp_id));
      rq_data.push_back(longint'(rsp_data));
      rq_cyc.push_back(cycnum);
      rsp_cnt <= rsp_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    rq_id.delete();
    rq_data.delete();
    rq_cyc.delete();
  endtask

  // One isolated request with exact latency checks.
  task automatic single(input string tag, input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    logic [NREQ-1:0] rdy;
    rdy = '0;
    rdy[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid = rdy;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(rdy));
    cyc(1);
    req_valid = '0;
    check({tag, "_mul_a"}, 64'(mul_a), 64'(a));
    check({tag, "_mul_b"}, 64'(mul_b), 64'(b));
    cyc(LAT);
    check({tag, "_early_rsp"}, 64'(rsp_valid), 64'd0);
    check({tag, "_busy_inflight"}, 64'(busy), 64'd1);
    cyc(1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    cyc(1);
    check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    // Reset values, and req_ready held low during reset even with requests pending.
    req_valid = '1;
    cyc(2);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issue_cnt", 64'(issue_cnt), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    cyc(1);

    // Single request from requester 2.
    clear_q();
    single("single", 2, 18'd3, 18'd5, 36'd15);
    check("single_cnt", 64'(issue_cnt), 64'd1);

    // All four valid after reset: grants 0..3 on consecutive cycles.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    clear_q();
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = 18'd10;
    end
    req_valid = 4'b1111;
    #1;
    check("all_grant0", 64'(req_ready), 64'b0001);
    cyc(1);
    req_valid[0] = 1'b0;
    #1;
    check("all_grant1", 64'(req_ready), 64'b0010);
    cyc(1);
    req_valid[1] = 1'b0;
    #1;
    check("all_grant2", 64'(req_ready), 64'b0100);
    cyc(1);
    req_valid[2] = 1'b0;
    #1;
    check("all_grant3", 64'(req_ready), 64'b1000);
    cyc(1);
    req_valid[3] = 1'b0;
    cyc(LAT + 4);
    check("all_issue_cnt", 64'(issue_cnt), 64'd4);
    check("all_rsp_count", 64'(rq_id.size()), 64'd4);
    if (rq_id.size() == 4) begin
      check("all_id0", 64'(rq_id[0]), 64'd0);
      check("all_id3", 64'(rq_id[3]), 64'd3);
      check("all_data0", 64'(rq_data[0]), 64'd10);
      check("all_data1", 64'(rq_data[1]), 64'd20);
      check("all_data2", 64'(rq_data[2]), 64'd30);
      check("all_data3", 64'(rq_data[3]), 64'd40);
      check("all_b2b", 64'(rq_cyc[3] - rq_cyc[0]), 64'd3);
    end

    // Requesters 1 and 3 compete for 8 cycles: strict alternation.
    clear_q();
    req_a[1*W +: W] = 18'd2;
    req_b[1*W +: W] = 18'd7;
    req_a[3*W +: W] = 18'd4;
    req_b[3*W +: W] = 18'd9;
    req_valid = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("alt_grant", 64'(req_ready), (k % 2 == 0) ? 64'b0010 : 64'b1000);
      cyc(1);
    end
    req_valid = '0;
    cyc(LAT + 4);
    check("alt_rsp_count", 64'(rq_id.size()), 64'd8);
    if (rq_id.size() == 8) begin
      check("alt_id6", 64'(rq_id[6]), 64'd1);
      check("alt_id7", 64'(rq_id[7]), 64'd3);
      check("alt_data4", 64'(rq_data[4]), 64'd14);
      check("alt_data5", 64'(rq_data[5]), 64'd36);
    end

    // Full-width product.
    single("max", 0, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001);

    // Reset with three issues in flight.
    req_a[0 +: W] = 18'd11;
    req_b[0 +: W] = 18'd13;
    req_valid = 4'b0001;
    cyc(3);
    req_valid = '0;
    clear_q();
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cnt", 64'(issue_cnt), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_id", 64'(rsp_id), 64'd0);
    check("midrst_rsp_data", 64'(rsp_data), 64'd0);
    check("midrst_mul_a", 64'(mul_a), 64'd0);
    cyc(1);
    rst = 1'b0;
    cyc(LAT + 4);
    check("midrst_no_rsp", 64'(rq_id.size()), 64'd0);
    single("postrst", 1, 18'd6, 18'd7, 36'd42);

    // Counter wrap with a continuous stream from requester 0.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    clear_q();
    rsp_cnt = 0;
    req_a[0 +: W] = 18'd1;
    req_b[0 +: W] = 18'd1;
    req_valid = 4'b0001;
    cyc(65537);
    req_valid = '0;
    check("wrap_cnt", 64'(issue_cnt), 64'd1);
    cyc(LAT + 4);
    check("wrap_rsp_count", 64'(rsp_cnt), 64'd65537);
    if (rq_cyc.size() > 0) check("wrap_no_gaps", 64'(rq_cyc[$] - rq_cyc[0]), 64'd65536);
    check("wrap_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one pipelined 18x18 unsigned multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the multiplier. Each issue is tagged with the requester index, and the tag travels alongside the multiplier pipeline so every product returns to its owner. The block sits between the requesting datapath units and the existing fixed-latency multiplier, which has no stall and no reset.

## Interface

Parameters:
- NREQ, default 4: number of requesters (2..8).
- W, default 18: operand width; products are 2*W bits.
- LAT, default 4: edges from the multiplier sampling mul_a/mul_b to mul_p holding the product.
- IDW, default $clog2(NREQ): width of the requester index.

Ports:
- clk  in  1: single clock; all state changes on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- req_valid  in  NREQ: request valid, one bit per requester.
- req_a  in  NREQ*W: operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W: operand B; same packing as req_a.
- req_ready  out  NREQ: grant, one-hot or zero, combinational.
- mul_a  out  W: registered operand A to the multiplier.
- mul_b  out  W: registered operand B to the multiplier.
- mul_p  in  2*W: product from the multiplier.
- rsp_valid  out  1: single-cycle pulse, product available.
- rsp_id  out  IDW: requester that owns rsp_data.
- rsp_data  out  2*W: product.
- busy  out  1: any issue is still in flight.
- issue_cnt  out  16: count of accepted requests; wraps from 0xFFFF to 0.

## Operation

- Arbitration (combinational):
  - Priority search starts at ptr and proceeds ptr, ptr+1, … modulo NREQ.
  - The first requester with req_valid=1 receives req_ready=1; all others see 0.
  - No request pending -> req_ready is all zero.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] is high at a rising edge.
  - A requester holds req_valid, req_a and req_b stable until it is granted.
  - The block never drops an asserted request.
- On each transfer edge:
  - mul_a and mul_b take the granted operands.
  - Stage 0 of the tag pipeline takes {valid=1, id=i}.
  - ptr becomes (i+1) mod NREQ.
  - issue_cnt increments.
- On an edge with no transfer:
  - Stage-0 valid becomes 0.
  - mul_a and mul_b hold their value.
  - ptr holds.
- Tag pipeline:
  - LAT+1 stages of {valid, id}; stages 1..LAT shift every cycle unconditionally.
  - Stage LAT is aligned with mul_p.
- Response register:
  - At each edge it captures rsp_valid = stage LAT valid.
  - rsp_id takes stage LAT id and rsp_data takes mul_p, but both update only when stage LAT is valid.
  - Otherwise rsp_id and rsp_data hold their previous value.
- Ordering and capacity:
  - Responses return in issue order.
  - There is no response backpressure; consumers accept rsp_valid in the cycle it is high.
- busy = OR of all tag-stage valid bits.
- Arithmetic: unsigned, full 2*W-bit product with no truncation. The block does no arithmetic beyond the issue_cnt increment.

## Timing

- Request to response:
  - Handshake at edge E; mul_a/mul_b are valid after E.
  - The multiplier samples them at E+1, and mul_p is valid after E+LAT.
  - rsp_valid is high in the cycle following edge E+LAT+1, so rsp_valid rises LAT+1 cycles after the handshake edge (5 at default).
- Throughput: one issue per cycle, sustained indefinitely. Back-to-back grants produce back-to-back rsp_valid pulses.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,…,NREQ-1,0,…. No requester waits more than NREQ-1 cycles after raising req_valid.
- Reset values (asynchronous, applied immediately on rst=1):
  - ptr = 0; all tag stages invalid.
  - mul_a = mul_b = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - issue_cnt = 0; busy = 0.
- req_ready is forced to 0 while rst=1.
- Reset mid-operation:
  - All in-flight results are discarded and never reported.
  - Stale mul_p values after reset release are ignored because all tags are invalid.
- req_valid dropping without a grant is a protocol violation; the block's behaviour in that case is unspecified but is never a hang.

## Test plan

- Single request: requester 2 sends a=3, b=5 at edge E. Required: req_ready[2] is high that cycle; rsp_valid=1, rsp_id=2, rsp_data=15 exactly LAT+1 cycles later; busy deasserts the cycle after.
- All four requesters valid at once after reset, with a=i+1 and b=10. Required: grants in order 0,1,2,3 on consecutive cycles; four consecutive responses with ids 0..3 and data 10, 20, 30, 40; issue_cnt=4.
- Requesters 1 and 3 continuously valid for 8 cycles. Required: grants alternate 1,3,1,3,… and neither requester is ever granted twice in a row.
- Maximum operands a=b=0x3FFFF. Required: rsp_data=0xFFFF80001 with no truncation.
- Three issues in flight, then rst pulsed for one cycle. Required: no rsp_valid afterwards; all outputs show reset values; a new request issued after release returns correctly with the normal latency.
- Issue 65537 requests. Required: issue_cnt wraps to 1; the response count matches the issue count with no gaps.
